// File: rtl/modular_adder_pkg.sv
// Shared types and the parallel-prefix combine operator for the modular adder.
package modular_adder_pkg;

  localparam int N_DEF = 7;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // (gh,ph) o (gl,pl) = (gh | ph&gl, ph&pl)
  function automatic gp_t prefix_op(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/modular_adder_prefix_network.sv
// Sklansky parallel-prefix network: group generate G[i:0] for every bit position.
module prefix_network
  import modular_adder_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] g_i,
  input  logic [N-1:0] p_i,
  output logic [N-1:0] grp_g_o
);

  localparam int L = $clog2(N);

  gp_t node [0:L][0:N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[0][i] = {g_i[i], p_i[i]};
  end

  // At level l, every node whose bit l is set absorbs the last node of the lower block.
  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_col
      if (((i >> l) & 1) == 1) begin : g_op
        assign node[l+1][i] = prefix_op(node[l][i], node[l][((i >> l) << l) - 1]);
      end else begin : g_pass
        assign node[l+1][i] = node[l][i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign grp_g_o[i] = node[L][i].g;
  end

endmodule

// File: rtl/modular_adder.sv
// Modulo adder: sum = carry(a+b+k) ? (a+b+k) mod 2^N : a+b, with k = 2^N - M.
// Define MODULAR_ADDER_IN_REG_EN to register the inputs first (latency 2 instead of 1).
module modular_adder
  import modular_adder_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic [N-1:0] sum,
  output logic         sum_valid,
  output logic         wrap
);

  // Handshake: in_valid is a one-way strobe with no ready; every cycle it is high
  // is accepted, and sum_valid pulses for exactly one cycle per accepted operation.

  logic [N-1:0] a_s, b_s, k_s;
  logic         vld_s;

`ifdef MODULAR_ADDER_IN_REG_EN
  logic [N-1:0] a_q, b_q, k_q;
  logic         vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      k_q   <= k;
      vld_q <= in_valid;
    end
  end

  assign a_s   = a_q;
  assign b_s   = b_q;
  assign k_s   = k_q;
  assign vld_s = vld_q;
`else
  assign a_s   = a;
  assign b_s   = b;
  assign k_s   = k;
  assign vld_s = in_valid;
`endif

  // Plain path operands
  logic [N-1:0] g, p, h;
  assign g = a_s & b_s;
  assign p = a_s ^ b_s;
  assign h = a_s ^ b_s;

  // Enveloped path: carry-save a+b+k into (h', c'), then form g'/p' against c' shifted up
  logic [N-1:0] hp, cp, cp_sh, gp_v, pp_v;
  assign hp    = a_s ^ b_s ^ k_s;
  assign cp    = (a_s & b_s) | (a_s & k_s) | (b_s & k_s);
  assign cp_sh = {cp[N-2:0], 1'b0};
  assign gp_v  = hp & cp_sh;
  assign pp_v  = hp ^ cp_sh;

  logic [N-1:0] grp_g, grp_gp;

  prefix_network #(.N(N)) u_prefix_plain (
    .g_i     (g),
    .p_i     (p),
    .grp_g_o (grp_g)
  );

  prefix_network #(.N(N)) u_prefix_env (
    .g_i     (gp_v),
    .p_i     (pp_v),
    .grp_g_o (grp_gp)
  );

  // Plain carry-out is not needed: a+b never overflows when the plain path is chosen.
  logic unused_plain_cout;
  assign unused_plain_cout = grp_g[N-1];

  logic [N-1:0] s_plain, s_env;
  logic         sel;
  assign s_plain = h ^ {grp_g[N-2:0], 1'b0};
  assign s_env   = pp_v ^ {grp_gp[N-2:0], 1'b0};
  assign sel     = cp[N-1] | grp_gp[N-1];

  logic [N-1:0] sum_q, sum_d;
  logic         wrap_q, wrap_d;
  logic         valid_q;

  always_comb begin
    sum_d  = sum_q;
    wrap_d = wrap_q;
    if (vld_s) begin
      sum_d  = sel ? s_env : s_plain;
      wrap_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      wrap_q  <= wrap_d;
      valid_q <= vld_s;
    end
  end

  assign sum       = sum_q;
  assign wrap      = wrap_q;
  assign sum_valid = valid_q;

endmodule

// File: tb/tb_modular_adder.sv
// Randomized bench for modular_adder against an arithmetic reference model.
module tb_modular_adder;

  localparam int N = 7;
  localparam int W = N + 2;
`ifdef MODULAR_ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a, b, k;
  logic [N-1:0] sum;
  logic         sum_valid;
  logic         wrap;

  modular_adder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .k         (k),
    .sum       (sum),
    .sum_valid (sum_valid),
    .wrap      (wrap)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // {valid, wrap, sum} per applied cycle, oldest first
  logic [N-1:0] exp_sum;
  logic         exp_wrap;
  logic         exp_valid;
  int           n_checks;
  int           n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Reference: carry out of a+b+k selects the wrapped sum, otherwise a+b.
  function automatic logic [N:0] ref_add(input logic [N-1:0] av, bv, kv);
    longint unsigned t;
    longint unsigned m;
    m = 64'd1 << N;
    t = longint'(av) + longint'(bv) + longint'(kv);
    if (t >= m) return {1'b1, N'(t % m)};
    return {1'b0, N'(longint'(av) + longint'(bv))};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [N-1:0] av, bv, kv);
    logic [N:0] r;
    in_valid = v;
    a = av;
    b = bv;
    k = kv;
    r = ref_add(av, bv, kv);
    exp_q.push_back({v, r});
  endtask

  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      if (e[N+1]) begin
        exp_valid = 1'b1;
        exp_wrap  = e[N];
        exp_sum   = e[N-1:0];
      end
    end
    check("sum_valid", 64'(sum_valid), 64'(exp_valid));
    check("sum", 64'(sum), 64'(exp_sum));
    check("wrap", 64'(wrap), 64'(exp_wrap));
  endtask

  task automatic mid_reset();
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);
    check("rst_valid", 64'(sum_valid), 64'd0);
    exp_q.delete();
    exp_sum  = '0;
    exp_wrap = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_sum   = '0;
    exp_wrap  = 1'b0;
    exp_valid = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a = '0;
    b = '0;
    k = '0;

    #1;
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);
    check("reset_valid", 64'(sum_valid), 64'd0);
    #16;
    rst_n = 1'b1;

    // Directed cases, applied back-to-back
    drive(1'b1, 7'd127, 7'd64, 7'd64);  step();
    drive(1'b1, 7'd10,  7'd20, 7'd5);   step();
    drive(1'b1, 7'd100, 7'd27, 7'd1);   step();
    drive(1'b1, 7'd127, 7'd1,  7'd0);   step();
    drive(1'b1, 7'd0,   7'd0,  7'd0);   step();
    drive(1'b1, 7'd127, 7'd127, 7'd127); step();
    drive(1'b1, 7'd5,   7'd7,  7'd1);   step();
    // Idle: results must hold with sum_valid low
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 7'(i), 7'(i + 3), 7'd9);
      step();
    end

    // Random stream with gaps and one reset in the middle
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) mid_reset();
      drive(($urandom_range(0, 9) < 8), N'($urandom), N'($urandom), N'($urandom));
      step();
    end

    for (int i = 0; i < LAT + 1; i++) begin
      drive(1'b0, '0, '0, '0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modular_adder.md
MODULAR_ADDER -- requirements
Module: modular_adder

Interface
REQ-001 SHALL have parameter N, default 7: operand, modulus-controller and sum width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a, b, k are sampled on this clk edge.
REQ-005 SHALL have port a, input, N bits: first operand, unsigned.
REQ-006 SHALL have port b, input, N bits: second operand, unsigned.
REQ-007 SHALL have port k, input, N bits: modulo controller, with k = 2^N - M for modulus M.
REQ-008 SHALL have port sum, output, N bits: registered result.
REQ-009 SHALL have port sum_valid, output, 1 bit: sum holds a new result this cycle.
REQ-010 SHALL have port wrap, output, 1 bit: registered select flag, 1 when the corrected path was chosen.

Function
REQ-011 Preprocessing stage SHALL form plain vectors g=a&b, p=a^b and h=a^b, bitwise.
REQ-012 Enveloped cells SHALL carry-save a, b and k: h'=a^b^k and c'=maj(a,b,k).
REQ-013 Enveloped cells SHALL form g'_i=h'_i&c'_(i-1) and p'_i=h'_i^c'_(i-1), with c'_(-1)=0.
REQ-014 Parallel-prefix stage SHALL compute the group generate G[i:0] for both the (g,p) and (g',p') vectors.
REQ-015 The prefix stage SHALL use the operator (gh,ph)o(gl,pl)=(gh|ph&gl, ph&pl).
REQ-016 The prefix stage SHALL use a Sklansky network of ceil(log2 N) levels.
REQ-017 Plain-path sum bits SHALL be s_i=h_i^G[i-1:0], with G[-1:0]=0.
REQ-018 Corrected-path sum bits SHALL be s'_i=p'_i^G'[i-1:0].
REQ-019 sel SHALL equal c'_(N-1) | G'[N-1:0], which is the carry-out of a+b+k.
REQ-020 The registered result SHALL be: sum = sel ? s' : s, and wrap = sel.
REQ-021 Equivalently, sum SHALL equal (a+b+k >= 2^N) ? (a+b+k) mod 2^N : a+b.
REQ-022 Latency SHALL be 1 clk: inputs sampled at edge t appear on sum/wrap after edge t, with sum_valid=1 for that one cycle.
REQ-023 No backpressure; a new operation MAY be accepted every cycle.
REQ-024 When in_valid=0, sum and wrap SHALL hold their values and sum_valid SHALL go to 0.
REQ-025 All datapath logic before the output register SHALL be combinational, with no latches.

Reset
REQ-026 While rst_n=0, sum=0, wrap=0 and sum_valid=0, immediately and independent of clk.
REQ-027 An operation in flight when reset asserts SHALL be discarded.
REQ-028 The first valid result SHALL follow the first in_valid sampled after rst_n deasserts.

Configuration
REQ-029 Macro MODULAR_ADDER_IN_REG_EN SHALL be the single compile-time feature switch.
REQ-030 When MODULAR_ADDER_IN_REG_EN is defined, a, b, k and in_valid SHALL be registered first, and latency SHALL be 2 clk.
REQ-031 The input registers SHALL reset to 0 asynchronously on rst_n.
REQ-032 When MODULAR_ADDER_IN_REG_EN is undefined, latency SHALL be 1 clk, and sum values SHALL be identical to the defined case for the same stimulus.

Structure
REQ-033 Package modular_adder_pkg SHALL hold the default width constant N_DEF=7 and a gp_t struct {g,p}.
REQ-034 Package modular_adder_pkg SHALL also hold the prefix-operator function.
REQ-035 One sub-module SHALL exist: prefix_network, N-parameterised, instantiated twice (plain and enveloped paths).
REQ-036 Preprocessing, enveloped-cell logic, sum selection and registers SHALL be implemented inline in modular_adder.

Verification (N=7, default configuration)
REQ-037 a=127, b=64, k=64, in_valid=1 -> after 1 clk: sum=127, wrap=1, sum_valid=1.
REQ-038 a=10, b=20, k=5 -> sum=30, wrap=0.
REQ-039 a=100, b=27, k=1 (mod 127) -> sum=0, wrap=1.
REQ-040 a=127, b=1, k=0 -> sum=0, wrap=1; a=0, b=0, k=0 -> sum=0, wrap=0.
REQ-041 Back-to-back: 3 operands on consecutive cycles -> 3 consecutive results with sum_valid=1; in_valid=0 afterwards -> sum held, sum_valid=0.
REQ-042 rst_n low mid-stream -> sum=0, wrap=0, sum_valid=0 without a clk edge; random 10^4 vectors compared against REQ-021 in both macro settings.
